// File: rtl/disp_pkg.sv
// Shared constants for the 7-segment scan path: active-low segment patterns
// (a..g in bits 7..1, dp in bit 0) and the per-slot phase type.
package disp_pkg;

    localparam int unsigned SEG_A_BIT  = 7;
    localparam int unsigned SEG_B_BIT  = 6;
    localparam int unsigned SEG_C_BIT  = 5;
    localparam int unsigned SEG_D_BIT  = 4;
    localparam int unsigned SEG_E_BIT  = 3;
    localparam int unsigned SEG_F_BIT  = 2;
    localparam int unsigned SEG_G_BIT  = 1;
    localparam int unsigned SEG_DP_BIT = 0;

    localparam logic [7:0] SEG_0    = 8'b0000_0011;
    localparam logic [7:0] SEG_1    = 8'b1001_1111;
    localparam logic [7:0] SEG_2    = 8'b0010_0101;
    localparam logic [7:0] SEG_3    = 8'b0000_1101;
    localparam logic [7:0] SEG_4    = 8'b1001_1001;
    localparam logic [7:0] SEG_5    = 8'b0100_1001;
    localparam logic [7:0] SEG_6    = 8'b0100_0001;
    localparam logic [7:0] SEG_7    = 8'b0001_1111;
    localparam logic [7:0] SEG_8    = 8'b0000_0001;
    localparam logic [7:0] SEG_9    = 8'b0000_1001;
    localparam logic [7:0] SEG_DASH = 8'b1111_1101;
    localparam logic [7:0] SEG_OFF  = 8'hFF;

    typedef enum logic {
        PH_BLANK,
        PH_SHOW
    } slot_phase_e;

endpackage

// File: rtl/bcd_seg_dec.sv
// BCD to active-low a..g decoder; codes 10-15 show a dash.
module bcd_seg_dec
    import disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0[SEG_A_BIT:SEG_G_BIT];
            4'd1:    seg = SEG_1[SEG_A_BIT:SEG_G_BIT];
            4'd2:    seg = SEG_2[SEG_A_BIT:SEG_G_BIT];
            4'd3:    seg = SEG_3[SEG_A_BIT:SEG_G_BIT];
            4'd4:    seg = SEG_4[SEG_A_BIT:SEG_G_BIT];
            4'd5:    seg = SEG_5[SEG_A_BIT:SEG_G_BIT];
            4'd6:    seg = SEG_6[SEG_A_BIT:SEG_G_BIT];
            4'd7:    seg = SEG_7[SEG_A_BIT:SEG_G_BIT];
            4'd8:    seg = SEG_8[SEG_A_BIT:SEG_G_BIT];
            4'd9:    seg = SEG_9[SEG_A_BIT:SEG_G_BIT];
            default: seg = SEG_DASH[SEG_A_BIT:SEG_G_BIT];
        endcase
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed common-anode display scanner with double-buffered frame,
// blank gap per slot, leading-zero suppression, blink and decimal points.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYC    = 64,
    parameter int unsigned BLINK_FRAMES = 125
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    lz_blank,
    input  logic                    update,
    output logic                    upd_ack,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              seg,
    output logic                    frame_done
);

    localparam int unsigned DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [DIV_W-1:0]        div_cnt;
    logic [SLOT_W-1:0]       slot;
    logic [FRM_W-1:0]        frame_cnt;
    logic                    blink_phase;
    logic [4*NUM_DIGITS-1:0] stage_dig, disp_dig;
    logic [NUM_DIGITS-1:0]   stage_dp, disp_dp;
    logic                    pending;

    logic                    slot_end, boundary;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    nz_seen;
    logic [3:0]              cur_bcd;
    logic                    cur_dp, cur_dark;
    logic [6:0]              dec_seg;
    slot_phase_e             phase;
    logic [NUM_DIGITS-1:0]   an_nxt;
    logic [7:0]              seg_nxt;

    assign slot_end   = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign boundary   = slot_end && (slot == SLOT_W'(NUM_DIGITS - 1));
    assign frame_done = boundary & ~rst;
    assign upd_ack    = boundary & ~rst & (pending | update);

    // Suppress from the top digit down until the first nonzero; digit 0 always shows.
    always_comb begin
        lz_mask = '0;
        nz_seen = 1'b0;
        for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
            nz_seen    = nz_seen | (disp_dig[4*i +: 4] != 4'd0);
            lz_mask[i] = lz_blank & ~nz_seen;
        end
    end

    always_comb begin
        cur_bcd  = '0;
        cur_dp   = 1'b0;
        cur_dark = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (slot == SLOT_W'(i)) begin
                cur_bcd  = disp_dig[4*i +: 4];
                cur_dp   = disp_dp[i];
                cur_dark = lz_mask[i] | (blink_phase & blink_mask[i]);
            end
        end
    end

    bcd_seg_dec u_dec (
        .bcd (cur_bcd),
        .seg (dec_seg)
    );

    always_comb begin
        phase   = (div_cnt < DIV_W'(BLANK_CYC)) ? PH_BLANK : PH_SHOW;
        an_nxt  = '1;
        seg_nxt = SEG_OFF;
        if (phase == PH_SHOW && !cur_dark) begin
            an_nxt                         = ~(NUM_DIGITS'(1) << slot);
            seg_nxt[SEG_A_BIT:SEG_G_BIT]   = dec_seg;
            seg_nxt[SEG_DP_BIT]            = ~cur_dp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an          <= '1;
            seg         <= SEG_OFF;
            div_cnt     <= '0;
            slot        <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            stage_dig   <= '0;
            stage_dp    <= '0;
            disp_dig    <= '0;
            disp_dp     <= '0;
            pending     <= 1'b0;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;

            if (slot_end) begin
                div_cnt <= '0;
                slot    <= (slot == SLOT_W'(NUM_DIGITS - 1)) ? '0 : slot + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (boundary) begin
                if (frame_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end

            // An update landing on the boundary bypasses staging straight to display.
            if (update) begin
                stage_dig <= digits_in;
                stage_dp  <= dp_in;
            end
            if (boundary && update) begin
                disp_dig <= digits_in;
                disp_dp  <= dp_in;
                pending  <= 1'b0;
            end else if (boundary && pending) begin
                disp_dig <= stage_dig;
                disp_dp  <= stage_dp;
                pending  <= 1'b0;
            end else if (update) begin
                pending <= 1'b1;
            end
        end
    end

endmodule
